// File: rtl/riscv_delay_sequencer.sv
// Request FIFO feeding an external down counter: each queued delay is loaded once,
// the block then waits for the counter's zero flag and pulses done.
module riscv_delay_sequencer #(
    parameter int DW    = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [DW-1:0]            req_data,
    output logic                     req_ready,
    input  logic                     abort,
    output logic                     ld_en,
    output logic [DW-1:0]            ld_val,
    input  logic                     cnt_oflag,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t            state;
    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [DW-1:0]     head;
    logic              full, empty, push, pop;

    assign head      = mem[rd_ptr];
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full && !abort;
    assign push      = req_valid && req_ready;
    // The head is only consumed while in LOAD, so it is stable on entry to LOAD.
    assign pop       = (state == LOAD);
    assign level     = count;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= req_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ld_en  <= 1'b0;
            ld_val <= '0;
            done   <= 1'b0;
        end else if (abort) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ld_en  <= 1'b0;
            ld_val <= '0;
            done   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            ld_en  <= 1'b0;
            ld_val <= '0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state  <= LOAD;
                        ld_en  <= (head != '0);
                        ld_val <= head;
                    end
                end
                LOAD: begin
                    // A zero delay skips the counter entirely.
                    if (head != '0) begin
                        state <= WAIT;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_oflag) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!empty) begin
                        state  <= LOAD;
                        ld_en  <= (head != '0);
                        ld_val <= head;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
